// File: rtl/binary_div_24_12_uni.sv
// Sequential unsigned restoring divider: DW-bit dividend by VW-bit divisor.
// One quotient bit is produced per enabled clock, MSB first, so a result is
// ready DW enabled edges after a start is accepted. A zero divisor still runs
// the full sequence and reports an all-ones quotient with the dz flag set.
module binary_div_24_12_uni #(
  parameter int DW = 24,
  parameter int VW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [DW-1:0] N,
  input  logic [VW-1:0] D,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          busy,
  output logic          done,
  output logic          dz
);

  localparam int CW = $clog2(DW);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] cnt;
  // Shift register: dividend bits leave at the top while quotient bits
  // enter at the bottom, so after DW steps it holds the full quotient.
  logic [DW-1:0] work;
  logic [VW-1:0] div_reg;
  logic [VW-1:0] prem;

  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          take;
  logic [VW-1:0] prem_step;
  logic          last_step;

  // One restoring step plus next-state selection for the control FSM.
  always_comb begin
    trial      = {prem, work[DW-1]};
    diff       = trial - {1'b0, div_reg};
    take       = (trial >= {1'b0, div_reg});
    prem_step  = take ? diff[VW-1:0] : trial[VW-1:0];
    last_step  = (cnt == CW'(DW - 1));
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state register; frozen while the clock enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (en) begin
      state <= state_next;
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      work    <= '0;
      div_reg <= '0;
      prem    <= '0;
      Q       <= '0;
      R       <= '0;
      done    <= 1'b0;
      dz      <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work    <= N;
            div_reg <= D;
            prem    <= '0;
            cnt     <= '0;
          end
        end
        CALC: begin
          work <= {work[DW-2:0], take};
          prem <= prem_step;
          cnt  <= cnt + CW'(1);
          if (last_step) begin
            cnt  <= '0;
            done <= 1'b1;
            if (div_reg == '0) begin
              Q  <= '1;
              R  <= '0;
              dz <= 1'b1;
            end else begin
              Q  <= {work[DW-2:0], take};
              R  <= prem_step;
              dz <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);

endmodule

// File: doc/binary_div_24_12_uni.md
Name: binary_div_24_12_uni

Overview:
- Sequential unsigned restoring divider; the inverse companion to the 12x12 unsigned multiplier block.
- Divides a 24-bit dividend (multiplier product width) by a 12-bit divisor.
- Produces a 24-bit quotient and a 12-bit remainder, one quotient bit per cycle.
- Sits beside the multiplier in the arithmetic datapath; start/done handshake, clock-enable gating.

Parameters:
- DW, 24, dividend and quotient width.
- VW, 12, divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  clock enable; when 0 the block freezes all state.
- start  input  1  request; sampled only when en=1 and busy=0.
- N  input  DW  unsigned dividend; captured at accepted start.
- D  input  VW  unsigned divisor; captured at accepted start.
- Q  output  DW  quotient.
- R  output  VW  remainder.
- busy  output  1  operation in progress.
- done  output  1  one-cycle result-valid pulse.
- dz  output  1  divide-by-zero flag, valid with done.

Behaviour:
- Reset (rst=1, asynchronous): Q=0, R=0, busy=0, done=0, dz=0, state=IDLE, counter=0, operand registers=0.
  - Takes effect immediately, including mid-operation; any in-flight result is discarded.
- States:
  - IDLE: wait for start.
  - CALC: counter runs 0..DW-1.
- Start acceptance: at a posedge with en=1, start=1 and state IDLE.
  - N and D are latched, the partial remainder is cleared, counter=0, state goes to CALC, busy=1.
- CALC step (each enabled posedge): form trial = {partial_rem[VW-1:0], next dividend MSB}, width VW+1.
  - If trial >= D: partial_rem = trial - D and quotient bit = 1.
  - Otherwise: partial_rem = trial and quotient bit = 0.
  - Quotient bits are shifted in MSB-first.
- Completion: on the enabled posedge that executes step DW-1:
  - Q and R are loaded with the final values, done=1 for exactly one cycle.
  - busy=0, state goes to IDLE.
- Latency: start accepted at enabled edge k; Q/R/done valid after enabled edge k+DW (24 edges when en held high).
- Back-to-back: start may be accepted on the edge immediately after the one that raised done. done then falls and busy rises on that edge.
- Result hold: Q, R and dz hold the last result until the next completion or reset. done alone is a pulse.
- en=0: no register changes, including done. A done pulse in progress is stretched until the next enabled edge, where it clears normally.
- start while busy=1: ignored. Captured operands are unaffected.
- Divide by zero (captured D=0): full latency still applies.
  - At completion Q = all ones (0xFFFFFF), R=0, dz=1.
  - dz=0 on every non-zero-divisor completion.
- N < D: Q=0, R=N[VW-1:0].
- Width rule: the internal partial remainder is VW+1 bits during compare. R is always < D when D != 0, so R always fits VW bits.
- Operands are sampled only at acceptance. Changing N/D during CALC has no effect.

Test Plan:
- Reset, en=1, start with N=16707600, D=4095 -> after 24 edges done=1, Q=4080, R=0, dz=0; busy high for the 24 intervening cycles.
- N=100, D=7 -> Q=14, R=2. N=16777215, D=1 -> Q=16777215, R=0. N=16777215, D=4095 -> Q=4097, R=0. N=5, D=4095 -> Q=0, R=5.
- N=1234, D=0 -> after 24 edges Q=0xFFFFFF, R=0, dz=1. Next op N=100, D=7 -> dz returns to 0.
- Start N=100, D=7; change N/D and pulse start again at cycle 5 -> single done at edge 24 with Q=14, R=2. Then issue start in the cycle done is high -> second result arrives 24 edges later.
- Start N=100, D=7; drop en for 10 cycles mid-CALC -> outputs frozen during the gap, done after 34 clock edges total, Q=14, R=2.
- Assert rst at CALC cycle 12 between clock edges -> Q, R, busy, done, dz go to 0 immediately. After release, a new op N=16707600, D=4080 -> Q=4095, R=0.
